// File: rtl/ov7670_pkg.sv
// Shared OV7670 definitions for the capture, frame_buffer and vga_display
// blocks.
// Contents:
//   S_SYNC/S_FRAME - capture FSM state encodings
//   RGB565/RGB444  - channel field positions within the 16-bit word
//                    {byte0, byte1}
//   C_*            - default image geometry and decimation constants
package ov7670_pkg;

  localparam logic [0:0] S_SYNC  = 1'b0;  // waiting for vsync fall
  localparam logic [0:0] S_FRAME = 1'b1;  // capturing a frame

  // Channel LSB positions inside {byte0, byte1}.
  localparam int RGB565_R_LSB = 11;  // 5 bits
  localparam int RGB565_G_LSB = 5;   // 6 bits
  localparam int RGB565_B_LSB = 0;   // 5 bits
  localparam int RGB444_R_LSB = 8;   // 4 bits
  localparam int RGB444_G_LSB = 4;   // 4 bits
  localparam int RGB444_B_LSB = 0;   // 4 bits

  // Default geometry shared with frame_buffer and vga_display.
  localparam int C_IMG_COLS    = 80;
  localparam int C_IMG_ROWS    = 60;
  localparam int C_NB_IMG_PXLS = 13;
  localparam int C_DEC_H       = 8;
  localparam int C_DEC_V       = 8;
  localparam int C_NB_BUF_CH   = 4;

  // Decimation wrap counters count 0..15, which covers decimation 1..16.
  localparam int C_NB_DEC_CNT  = 4;

endpackage

// File: rtl/ov_in_sync.sv
// Two-flop synchroniser for the OV7670 input bundle, plus a pclk rising-edge
// detector. pclk and the bus share the same depth, so the byte seen on
// o_bus in the o_pclk_rise cycle is the byte the sensor presented at that
// pclk edge.
// Ports:
//   clk, rst     - system clock, asynchronous active-low reset
//   i_pclk       - camera pixel clock (sampled as data)
//   i_bus        - remaining camera signals, W bits wide
//   o_bus        - synchronised bus
//   o_pclk_rise  - one-clk pulse on a synchronised pclk 0->1 transition
module ov_in_sync #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_pclk,
  input  logic [W-1:0] i_bus,
  output logic [W-1:0] o_bus,
  output logic         o_pclk_rise
);

  logic [W:0] r_meta;
  logic [W:0] r_sync;
  logic       r_pclk_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_meta   <= '0;
      r_sync   <= '0;
      r_pclk_d <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so each stage takes the previous
      // stage's old value and the chain really is two flops deep.
      r_meta   <= {i_pclk, i_bus};
      r_sync   <= r_meta;
      r_pclk_d <= r_sync[W];
    end
  end

  assign o_bus       = r_sync[W-1:0];
  assign o_pclk_rise = r_sync[W] & ~r_pclk_d;

endmodule

// File: rtl/ov7670_capture_dec.sv
// OV7670 capture with 2-D decimation and RGB565/RGB444 input selection.
// Bytes are assembled into pixels. Every c_dec_h-th pixel of every
// c_dec_v-th line is kept, truncated to the buffer channel widths, and
// written through the frame_buffer write port.
// Optional feature: macro OV_CAP_DBLBUF_EN adds a bank bit as the addr MSB
// and a disp_bank output.
// Ports:
//   clk, rst            - 100 MHz system clock, asynchronous active-low reset
//   pclk, vsync, href   - camera timing; all are sampled, none is a clock
//   data                - camera byte
//   fmt_565             - 1 = RGB565, 0 = xRGB444; latched at frame start
//   addr, dout, we      - frame_buffer write port
//   frame_done          - 1-clk pulse when a full frame has been written
//   frame_short         - 1-clk pulse when vsync rises before the frame is full
//   disp_bank           - (OV_CAP_DBLBUF_EN only) bank the display should read
module ov7670_capture_dec
  import ov7670_pkg::*;
#(
  parameter int c_img_cols     = C_IMG_COLS,
  parameter int c_img_rows     = C_IMG_ROWS,
  parameter int c_nb_img_pxls  = C_NB_IMG_PXLS,
  parameter int c_dec_h        = C_DEC_H,
  parameter int c_dec_v        = C_DEC_V,
  parameter int c_nb_buf_red   = C_NB_BUF_CH,
  parameter int c_nb_buf_green = C_NB_BUF_CH,
  parameter int c_nb_buf_blue  = C_NB_BUF_CH,
  localparam int c_nb_buf      = c_nb_buf_red + c_nb_buf_green + c_nb_buf_blue
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pclk,
  input  logic                     vsync,
  input  logic                     href,
  input  logic [7:0]               data,
  input  logic                     fmt_565,
`ifdef OV_CAP_DBLBUF_EN
  output logic [c_nb_img_pxls:0]   addr,
`else
  output logic [c_nb_img_pxls-1:0] addr,
`endif
  output logic [c_nb_buf-1:0]      dout,
  output logic                     we,
  output logic                     frame_done,
  output logic                     frame_short
`ifdef OV_CAP_DBLBUF_EN
  ,
  output logic                     disp_bank
`endif
);

  localparam int C_NB_COL = $clog2(c_img_cols + 1);
  localparam int C_NB_ROW = $clog2(c_img_rows + 1);
  localparam logic [C_NB_COL-1:0]      C_COL_END   = C_NB_COL'(c_img_cols);
  localparam logic [C_NB_COL-1:0]      C_COL_LAST  = C_NB_COL'(c_img_cols - 1);
  localparam logic [C_NB_ROW-1:0]      C_ROW_END   = C_NB_ROW'(c_img_rows);
  localparam logic [C_NB_ROW-1:0]      C_ROW_LAST  = C_NB_ROW'(c_img_rows - 1);
  localparam logic [c_nb_img_pxls-1:0] C_ROW_STEP  = c_nb_img_pxls'(c_img_cols);
  localparam logic [C_NB_DEC_CNT-1:0]  C_DEC_H_LST = C_NB_DEC_CNT'(c_dec_h - 1);
  localparam logic [C_NB_DEC_CNT-1:0]  C_DEC_V_LST = C_NB_DEC_CNT'(c_dec_v - 1);

  // Synchronised inputs and edge detection
  logic [7:0] w_data;
  logic       w_href, w_vsync, w_pclk_rise;
  logic       r_href_d, r_vsync_d;

  ov_in_sync #(.W(10)) u_in_sync (
    .clk         (clk),
    .rst         (rst),
    .i_pclk      (pclk),
    .i_bus       ({href, vsync, data}),
    .o_bus       ({w_href, w_vsync, w_data}),
    .o_pclk_rise (w_pclk_rise)
  );

  logic w_href_fall, w_vs_fall, w_vs_rise;
  assign w_href_fall = r_href_d & ~w_href;
  assign w_vs_fall   = r_vsync_d & ~w_vsync;
  assign w_vs_rise   = ~r_vsync_d & w_vsync;

  // Capture state
  logic [0:0]               r_state;
  logic                     r_fmt565, r_byte_ph, r_full;
  logic [7:0]               r_hi;
  logic [C_NB_DEC_CNT-1:0]  r_col_mod, r_line_mod;
  logic [C_NB_COL-1:0]      r_out_col;
  logic [C_NB_ROW-1:0]      r_out_row;
  logic [c_nb_img_pxls-1:0] r_row_base, r_addr;
  logic [c_nb_buf-1:0]      r_dout;
  logic                     r_we, r_frame_done, r_frame_short;

  // A pixel survives only if both decimation phases are zero and it lies
  // inside the output image.
  logic w_col_keep, w_line_keep;
  assign w_col_keep  = (r_col_mod == '0) && (r_out_col < C_COL_END);
  assign w_line_keep = (r_line_mod == '0) && (r_out_row < C_ROW_END);

  // Each channel is left-aligned to its 565 width so that one MSB slice
  // serves both formats.
  logic [15:0] w_pix16;
  logic [4:0]  w_r5, w_b5;
  logic [5:0]  w_g6;
  assign w_pix16 = {r_hi, w_data};
  assign w_r5 = r_fmt565 ? w_pix16[RGB565_R_LSB +: 5] : {w_pix16[RGB444_R_LSB +: 4], 1'b0};
  assign w_g6 = r_fmt565 ? w_pix16[RGB565_G_LSB +: 6] : {w_pix16[RGB444_G_LSB +: 4], 2'b0};
  assign w_b5 = r_fmt565 ? w_pix16[RGB565_B_LSB +: 5] : {w_pix16[RGB444_B_LSB +: 4], 1'b0};

  // The channel LSBs below the stored widths are dropped on purpose.
  logic w_unused;
  assign w_unused = &{1'b0, w_r5, w_g6, w_b5};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_SYNC;
      r_href_d      <= 1'b0;
      r_vsync_d     <= 1'b0;
      r_fmt565      <= 1'b0;
      r_byte_ph     <= 1'b0;
      r_full        <= 1'b0;
      r_hi          <= '0;
      r_col_mod     <= '0;
      r_line_mod    <= '0;
      r_out_col     <= '0;
      r_out_row     <= '0;
      r_row_base    <= '0;
      r_addr        <= '0;
      r_dout        <= '0;
      r_we          <= 1'b0;
      r_frame_done  <= 1'b0;
      r_frame_short <= 1'b0;
    end else begin
      r_we          <= 1'b0;
      r_frame_done  <= 1'b0;
      r_frame_short <= 1'b0;
      r_href_d      <= w_href;
      r_vsync_d     <= w_vsync;

      if (r_state == S_SYNC) begin
        if (w_vs_fall) begin
          r_state    <= S_FRAME;
          r_fmt565   <= fmt_565;
          r_byte_ph  <= 1'b0;
          r_full     <= 1'b0;
          r_col_mod  <= '0;
          r_line_mod <= '0;
          r_out_col  <= '0;
          r_out_row  <= '0;
          r_row_base <= '0;
        end
      end else if (w_vs_rise) begin
        r_state       <= S_SYNC;
        r_frame_done  <= r_full;
        r_frame_short <= ~r_full;
      end else if (w_href_fall) begin
        // End of line: an odd trailing byte is discarded with the byte phase.
        r_byte_ph  <= 1'b0;
        r_col_mod  <= '0;
        r_out_col  <= '0;
        r_line_mod <= (r_line_mod == C_DEC_V_LST) ? '0 : r_line_mod + 1'b1;
        if (w_line_keep) begin
          r_out_row  <= r_out_row + 1'b1;
          r_row_base <= r_row_base + C_ROW_STEP;
        end
      end else if (w_pclk_rise && w_href) begin
        if (!r_byte_ph) begin
          r_hi      <= w_data;
          r_byte_ph <= 1'b1;
        end else begin
          r_byte_ph <= 1'b0;
          r_col_mod <= (r_col_mod == C_DEC_H_LST) ? '0 : r_col_mod + 1'b1;
          if (w_col_keep) r_out_col <= r_out_col + 1'b1;
          if (w_col_keep && w_line_keep) begin
            r_we   <= 1'b1;
            r_addr <= r_row_base + c_nb_img_pxls'(r_out_col);
            r_dout <= {w_r5[4 -: c_nb_buf_red], w_g6[5 -: c_nb_buf_green],
                       w_b5[4 -: c_nb_buf_blue]};
            if (r_out_col == C_COL_LAST && r_out_row == C_ROW_LAST) r_full <= 1'b1;
          end
        end
      end
    end
  end

  assign dout        = r_dout;
  assign we          = r_we;
  assign frame_done  = r_frame_done;
  assign frame_short = r_frame_short;

`ifdef OV_CAP_DBLBUF_EN
  // The bank advances only after a complete frame, so a short frame is
  // rewritten into the same bank and the display never sees it.
  logic r_bank;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_bank <= 1'b0;
    else if (r_state == S_FRAME && w_vs_rise && r_full) r_bank <= ~r_bank;
  end
  assign addr      = {r_bank, r_addr};
  assign disp_bank = ~r_bank;
`else
  assign addr = r_addr;
`endif

endmodule
